// File: rtl/check_tracker.sv
// check_tracker: NUM_CH pending flags with round-robin dispatch of un-issued channels.
// Optional per-channel timeout counters are built when CHECK_TIMEOUT_EN is defined.
module check_tracker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter int TIMEOUT = 200,
  localparam int ID_W = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             check_i,
  input  logic [NUM_CH-1:0]             done_i,
  output logic [NUM_CH-1:0]             check_o,
  output logic                          any_o,
  output logic [$clog2(NUM_CH+1)-1:0]   cnt_o,
  output logic                          sel_valid_o,
  output logic [ID_W-1:0]               sel_id_o,
  input  logic                          sel_ready_i,
  output logic [NUM_CH-1:0]             timeout_o
);
  logic [NUM_CH-1:0] issued, elig, grant, fresh, clr;
  logic [ID_W-1:0] ptr;
  logic hs;
  if (NUM_CH < 2 || TIMEOUT < 1 || TIMEOUT >= 2**CNT_W) begin : g_bad_cfg
    $error("check_tracker: illegal parameter combination");
  end
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return ID_W'(s >= NUM_CH ? s - NUM_CH : s);
  endfunction
  assign elig = check_o & ~issued;
  assign fresh = check_i & (~check_o | done_i);
  assign clr = fresh | (done_i & ~check_i);
  assign any_o = |check_o;
  assign hs = sel_valid_o & sel_ready_i;
  // Scan from the farthest offset down so the one nearest ptr wins.
  always_comb begin
    sel_valid_o = 1'b0;
    sel_id_o = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (elig[rr_idx(ptr, k)]) begin
        sel_valid_o = 1'b1;
        sel_id_o = rr_idx(ptr, k);
      end
  end
  always_comb begin
    grant = '0;
    cnt_o = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      grant[n] = hs && sel_id_o == ID_W'(n);
      cnt_o = cnt_o + $bits(cnt_o)'(check_o[n]);
    end
  end
  // Set wins over clear; a fresh arm drops any handshake landing in the same cycle.
  always_ff @(posedge clk)
    if (rst) begin
      check_o <= '0;
      issued <= '0;
      ptr <= '0;
    end else begin
      check_o <= check_i | (check_o & ~done_i);
      issued <= ~clr & (issued | grant);
      if (hs) ptr <= sel_id_o == ID_W'(NUM_CH - 1) ? '0 : sel_id_o + 1'b1;
    end
`ifdef CHECK_TIMEOUT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];
  always_ff @(posedge clk)
    if (rst) begin
      timeout_o <= '0;
      for (int n = 0; n < NUM_CH; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++)
        if (check_i[n] || done_i[n]) begin
          cnt[n] <= '0;
          timeout_o[n] <= 1'b0;
        end else if (check_o[n] && !timeout_o[n]) begin
          if (cnt[n] == CNT_W'(TIMEOUT - 1)) timeout_o[n] <= 1'b1;
          else cnt[n] <= cnt[n] + 1'b1;
        end
    end
`else
  assign timeout_o = '0;
`endif
endmodule
